alu_status_reg: RTL and testbench
=================================

Name: alu_status_reg

Overview:
- Stage directly downstream of the ALU datapath (logic circuit and adder).
- Registers the ALU result and, in the same cycle, computes and holds the MSP430 status flags C, Z, N, V in the SR (R2) image.
- Also accepts direct register-file writes to SR, since R2 can be an instruction destination.
- Provides a registered result with a valid strobe for the register-file writeback stage.

Parameters:
- SIZE, 16, datapath width; the byte-mode MSB index is fixed at 7.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- RES_VALID  input  1  ALU result on RESULT is valid this cycle.
- RESULT  input  SIZE  ALU output (logic or arithmetic unit, already muxed).
- SRC  input  SIZE  source operand as presented to the ALU, before inversion.
- DST  input  SIZE  destination operand.
- FS  input  4  ALU function select, same encoding as the ALU.
- CARRY_IN  input  1  adder carry-out at the active width, supplied by the adder.
- BW  input  1  1 = byte operation.
- FLAG_WE  input  1  instruction updates flags.
- SR_WE  input  1  register-file write to R2.
- SR_DIN  input  SIZE  data for the R2 write.
- RES_Q  output  SIZE  registered result.
- RES_VALID_Q  output  1  RES_Q valid, one cycle after RES_VALID.
- SR  output  SIZE  status register image.
- C, Z, N, V  output  1 each  individual flag taps, equal to SR bits.

Behaviour:
- Reset (async, RST_N=0):
  - RES_Q=0, RES_VALID_Q=0, SR=0 (all flags 0, GIE=0).
  - Release is sampled at the next CLK edge.
- SR bit map:
  - C=0, Z=1, N=2, GIE=3, CPUOFF=4, OSCOFF=5, SCG0=6, SCG1=7, V=8.
  - Bits 15:9 are reserved: always read 0 and are never written.
- Result path:
  - RES_Q <= RESULT and RES_VALID_Q <= RES_VALID on every edge. Latency is 1 cycle.
  - RES_Q is loaded even when RES_VALID=0, and is don't-care in that case.
- Width rules:
  - BW=0: msb = bit 15, Z computed over [15:0].
  - BW=1: msb = bit 7, Z computed over [7:0], upper byte ignored.
  - RES_Q is unmasked; upstream clears the upper byte in byte mode.
- Flag update: happens only when RES_VALID=1, FLAG_WE=1 and SR_WE=0.
- Arithmetic class (FS[2]=0):
  - N = msb(RESULT).
  - Z = (active bits == 0).
  - C = CARRY_IN.
  - V = (msb(A) == msb(DST)) && (msb(RESULT) != msb(A)), where A = FS[3] ? ~SRC : SRC.
- Logic class (FS[2]=1):
  - FS[1:0]=00 with FS[3]=0 (AND/BIT): N, Z as above; C = ~Z; V = 0.
  - FS[1:0]=10 (XOR): N, Z as above; C = ~Z; V = msb(SRC) & msb(DST).
  - FS[1:0]=00 with FS[3]=1 (BIC), FS[1:0]=01 (BIS), FS[1:0]=11 (MOV): all flags hold, even with FLAG_WE=1.
- Non-flag SR bits (GIE, CPUOFF, OSCOFF, SCG0, SCG1) change only via SR_WE.
- Direct write (SR_WE=1):
  - SR <= SR_DIN & 16'h01FF, independent of RES_VALID.
  - SR_WE has priority over a simultaneous flag update; the flag computation is discarded that cycle.
- Hold: with neither SR_WE nor a qualifying flag update, SR holds.
- Reset asserted mid-operation clears all state immediately; there is no pending update after release.
- The block has no combinational path from inputs to SR/flag outputs; every output is a flop.

Decomposition:
- Shared package holds:
  - the SR bit-index constants (SR_C … SR_V);
  - SR_RSVD_MASK = 16'h01FF;
  - FS field constants: FS_LOGIC bit = 2; op codes AND=00, OR=01, XOR=10, PASS=11; FS_INV bit = 3.
- One natural sub-module: flag_gen. It is combinational; inputs RESULT, SRC, DST, FS, CARRY_IN, BW; outputs next N/Z/C/V plus an upd_en qualifier. The top holds the registers and priority logic.

Test Plan:
- Reset: RST_N low mid-cycle, with SR previously 16'h0107 → SR=0 and RES_VALID_Q=0 asynchronously, before the next edge.
- ADD overflow:
  - Stimulus: FS=0000, BW=0, SRC=16'h7FFF, DST=16'h0001, RESULT=16'h8000, CARRY_IN=0, FLAG_WE=1, RES_VALID=1.
  - Response: next cycle N=1, Z=0, C=0, V=1, RES_Q=16'h8000, RES_VALID_Q=1.
- Byte SUB to zero:
  - Stimulus: FS=1000, BW=1, SRC=16'h0042, DST=16'hFF42, RESULT=16'hFF00, CARRY_IN=1.
  - Response: Z=1, N=0, C=1, V=0; the upper byte is ignored for Z.
- Logic ops:
  - AND: FS=0100, RESULT=0 → Z=1, C=0, V=0.
  - XOR: FS=0110, SRC=16'h8000, DST=16'h8001, RESULT=16'h0001 → Z=0, C=1, V=1, N=0.
  - Then BIS, FS=0101 with FLAG_WE=1 → all flags unchanged.
- Priority:
  - Same cycle: SR_WE=1 with SR_DIN=16'hFE08, plus a flag update that would set Z.
  - Response: SR=16'h0008 (GIE only, reserved bits masked, Z=0).
- Idle hold: RES_VALID=0, FLAG_WE=1 for 3 cycles → SR unchanged; RES_VALID_Q=0.

Source files
------------

// File: rtl/alu_status_reg_pkg.sv
// Shared constants for the ALU status stage: SR bit map, reserved-bit mask
// and the ALU function-select field layout.
package alu_status_reg_pkg;

  localparam int SR_C      = 0;
  localparam int SR_Z      = 1;
  localparam int SR_N      = 2;
  localparam int SR_GIE    = 3;
  localparam int SR_CPUOFF = 4;
  localparam int SR_OSCOFF = 5;
  localparam int SR_SCG0   = 6;
  localparam int SR_SCG1   = 7;
  localparam int SR_V      = 8;

  localparam logic [15:0] SR_RSVD_MASK = 16'h01FF;

  localparam int FS_LOGIC = 2;
  localparam int FS_INV   = 3;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_PASS = 2'b11
  } logic_op_e;

endpackage

// File: rtl/alu_status_reg_if.sv
// Bundle between the ALU datapath / register file and the status stage.
interface alu_status_reg_if #(
  parameter int SIZE = 16
);

  logic            res_valid;
  logic [SIZE-1:0] result;
  logic [SIZE-1:0] src;
  logic [SIZE-1:0] dst;
  logic [3:0]      fs;
  logic            carry_in;
  logic            bw;
  logic            flag_we;
  logic            sr_we;
  logic [SIZE-1:0] sr_din;

  logic [SIZE-1:0] res_q;
  logic            res_valid_q;
  logic [SIZE-1:0] sr;
  logic            c;
  logic            z;
  logic            n;
  logic            v;

  modport master (
    output res_valid, result, src, dst, fs, carry_in, bw, flag_we, sr_we, sr_din,
    input  res_q, res_valid_q, sr, c, z, n, v
  );

  modport slave (
    input  res_valid, result, src, dst, fs, carry_in, bw, flag_we, sr_we, sr_din,
    output res_q, res_valid_q, sr, c, z, n, v
  );

endinterface

// File: rtl/alu_status_reg_flag_gen.sv
// Combinational next-flag computation for one ALU result; upd_en_o is low
// for operations whose flags must be left untouched (BIC, BIS, MOV).
module alu_status_reg_flag_gen
  import alu_status_reg_pkg::*;
#(
  parameter int SIZE = 16
) (
  input  logic [SIZE-1:0] result_i,
  input  logic [SIZE-1:0] src_i,
  input  logic [SIZE-1:0] dst_i,
  input  logic [3:0]      fs_i,
  input  logic            carry_in_i,
  input  logic            bw_i,
  output logic            n_o,
  output logic            z_o,
  output logic            c_o,
  output logic            v_o,
  output logic            upd_en_o
);

  logic res_msb_s;
  logic src_msb_s;
  logic dst_msb_s;
  logic a_msb_s;
  logic zero_s;
  logic unused_bits_s;

  assign res_msb_s = bw_i ? result_i[7] : result_i[SIZE-1];
  assign src_msb_s = bw_i ? src_i[7]    : src_i[SIZE-1];
  assign dst_msb_s = bw_i ? dst_i[7]    : dst_i[SIZE-1];
  // Subtraction feeds the adder with ~SRC, so overflow is judged on that operand.
  assign a_msb_s   = fs_i[FS_INV] ? ~src_msb_s : src_msb_s;
  assign zero_s    = bw_i ? (result_i[7:0] == 8'h00) : (result_i == {SIZE{1'b0}});

  assign unused_bits_s = ^{src_i[SIZE-2:8], src_i[6:0], dst_i[SIZE-2:8], dst_i[6:0]};

  // Select flag values by operation class.
  always_comb begin
    n_o      = res_msb_s;
    z_o      = zero_s;
    c_o      = 1'b0;
    v_o      = 1'b0;
    upd_en_o = 1'b0;
    if (!fs_i[FS_LOGIC]) begin
      c_o      = carry_in_i;
      v_o      = (a_msb_s == dst_msb_s) && (res_msb_s != a_msb_s);
      upd_en_o = 1'b1;
    end else begin
      case (logic_op_e'(fs_i[1:0]))
        OP_AND: begin
          c_o      = ~zero_s;
          v_o      = 1'b0;
          upd_en_o = ~fs_i[FS_INV];
        end
        OP_XOR: begin
          c_o      = ~zero_s;
          v_o      = src_msb_s & dst_msb_s;
          upd_en_o = 1'b1;
        end
        OP_OR:   upd_en_o = 1'b0;
        OP_PASS: upd_en_o = 1'b0;
        default: upd_en_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/alu_status_reg.sv
// ALU writeback stage: registers the result and maintains the SR (R2) image,
// with register-file writes to R2 taking priority over flag updates.
module alu_status_reg
  import alu_status_reg_pkg::*;
#(
  parameter int SIZE = 16
) (
  input logic           clk,
  input logic           rst_n,
  alu_status_reg_if.slave bus
);

  logic [SIZE-1:0] res_q;
  logic            res_valid_q;
  logic [SIZE-1:0] sr_q;
  logic [SIZE-1:0] sr_d;

  logic n_s;
  logic z_s;
  logic c_s;
  logic v_s;
  logic upd_en_s;
  logic flag_upd_s;

  alu_status_reg_flag_gen #(
    .SIZE (SIZE)
  ) u_flag_gen (
    .result_i   (bus.result),
    .src_i      (bus.src),
    .dst_i      (bus.dst),
    .fs_i       (bus.fs),
    .carry_in_i (bus.carry_in),
    .bw_i       (bus.bw),
    .n_o        (n_s),
    .z_o        (z_s),
    .c_o        (c_s),
    .v_o        (v_s),
    .upd_en_o   (upd_en_s)
  );

  assign flag_upd_s = bus.res_valid & bus.flag_we & upd_en_s & ~bus.sr_we;

  // SR next-state: direct write, flag update, or hold.
  always_comb begin
    sr_d = sr_q;
    if (bus.sr_we) begin
      sr_d = bus.sr_din & SIZE'(SR_RSVD_MASK);
    end else if (flag_upd_s) begin
      sr_d[SR_C] = c_s;
      sr_d[SR_Z] = z_s;
      sr_d[SR_N] = n_s;
      sr_d[SR_V] = v_s;
    end else begin
      sr_d = sr_q;
    end
  end

  // Result, valid strobe and SR registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q       <= {SIZE{1'b0}};
      res_valid_q <= 1'b0;
      sr_q        <= {SIZE{1'b0}};
    end else begin
      res_q       <= bus.result;
      res_valid_q <= bus.res_valid;
      sr_q        <= sr_d;
    end
  end

  assign bus.res_q       = res_q;
  assign bus.res_valid_q = res_valid_q;
  assign bus.sr          = sr_q;
  assign bus.c           = sr_q[SR_C];
  assign bus.z           = sr_q[SR_Z];
  assign bus.n           = sr_q[SR_N];
  assign bus.v           = sr_q[SR_V];

endmodule

// File: tb/tb_alu_status_reg.sv
// Scoreboard bench for alu_status_reg: each driven cycle pushes the expected
// registered result/SR, popped and compared one cycle later.
module tb_alu_status_reg;

  typedef struct {
    logic [15:0] res;
    logic        rv;
    logic [15:0] sr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic [15:0] model_sr;

  alu_status_reg_if #(.SIZE(16)) bus ();

  alu_status_reg #(.SIZE(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] next_sr(
    input logic [15:0] cur, input logic rv, input logic [15:0] res,
    input logic [15:0] src, input logic [15:0] dst, input logic [3:0] fs,
    input logic cin, input logic bw, input logic fwe, input logic swe,
    input logic [15:0] sdin);
    int m;
    logic rmsb, smsb, dmsb, amsb, zf, cf, vf;
    logic [15:0] nxt;
    if (swe) return sdin & 16'h01FF;
    if (!(rv && fwe)) return cur;
    m    = bw ? 7 : 15;
    rmsb = res[m];
    smsb = src[m];
    dmsb = dst[m];
    zf   = bw ? (res[7:0] == 8'h00) : (res == 16'h0000);
    if (fs[2] == 1'b0) begin
      cf   = cin;
      amsb = fs[3] ? ~smsb : smsb;
      vf   = (amsb == dmsb) && (rmsb != amsb);
    end else if (fs[1:0] == 2'b10) begin
      cf = ~zf;
      vf = smsb & dmsb;
    end else if (fs == 4'b0100) begin
      cf = ~zf;
      vf = 1'b0;
    end else begin
      return cur;
    end
    nxt    = cur;
    nxt[0] = cf;
    nxt[1] = zf;
    nxt[2] = rmsb;
    nxt[8] = vf;
    return nxt;
  endfunction

  task automatic step(input logic rv, input logic [15:0] res, input logic [15:0] src,
                      input logic [15:0] dst, input logic [3:0] fs, input logic cin,
                      input logic bw, input logic fwe, input logic swe,
                      input logic [15:0] sdin);
    exp_t e;
    bus.res_valid = rv;
    bus.result    = res;
    bus.src       = src;
    bus.dst       = dst;
    bus.fs        = fs;
    bus.carry_in  = cin;
    bus.bw        = bw;
    bus.flag_we   = fwe;
    bus.sr_we     = swe;
    bus.sr_din    = sdin;
    model_sr = next_sr(model_sr, rv, res, src, dst, fs, cin, bw, fwe, swe, sdin);
    e.res = res;
    e.rv  = rv;
    e.sr  = model_sr;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop(output exp_t e, output bit ok);
    ok = (sb.size() > 0);
    if (ok) e = sb.pop_front();
    else begin
      e.res = 16'h0000; e.rv = 1'b0; e.sr = 16'h0000;
    end
  endtask

  task automatic test_reset;
    exp_t e;
    bit ok;
    rst_n = 1'b0;
    step(1'b0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    sb.delete();
    model_sr = 16'h0000;
    checks++;
    if (bus.sr !== 16'h0000 || bus.res_valid_q !== 1'b0 || bus.res_q !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: got sr=%h rvq=%b res=%h, expected 0/0/0", bus.sr, bus.res_valid_q, bus.res_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 16'h1234, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0107);
    sb_pop(e, ok);
    checks++;
    if (!ok || bus.sr !== e.sr || bus.res_valid_q !== e.rv || bus.sr !== 16'h0107) begin
      errors++;
      $display("FAIL preload_sr: got sr=%h rvq=%b, expected sr=0107 rvq=1", bus.sr, bus.res_valid_q);
    end
    bus.res_valid = 1'b0;
    bus.sr_we     = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.sr !== 16'h0000 || bus.res_valid_q !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got sr=%h rvq=%b, expected sr=0000 rvq=0", bus.sr, bus.res_valid_q);
    end
    sb.delete();
    model_sr = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.sr !== 16'h0000) begin
      errors++;
      $display("FAIL after_release: got sr=%h, expected 0000", bus.sr);
    end
  endtask

  task automatic test_add_overflow;
    exp_t e;
    bit ok;
    step(1'b1, 16'h8000, 16'h7FFF, 16'h0001, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    sb_pop(e, ok);
    checks++;
    if (!ok || bus.sr !== e.sr || bus.res_q !== e.res || bus.res_valid_q !== e.rv) begin
      errors++;
      $display("FAIL add_sb: got sr=%h res=%h rvq=%b, expected sr=%h res=%h rvq=%b",
               bus.sr, bus.res_q, bus.res_valid_q, e.sr, e.res, e.rv);
    end
    checks++;
    if ({bus.n, bus.z, bus.c, bus.v} !== 4'b1001 || bus.res_q !== 16'h8000 || bus.res_valid_q !== 1'b1) begin
      errors++;
      $display("FAIL add_flags: got nzcv=%b%b%b%b res=%h rvq=%b, expected nzcv=1001 res=8000 rvq=1",
               bus.n, bus.z, bus.c, bus.v, bus.res_q, bus.res_valid_q);
    end
  endtask

  task automatic test_byte_sub;
    exp_t e;
    bit ok;
    step(1'b1, 16'hFF00, 16'h0042, 16'hFF42, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    sb_pop(e, ok);
    checks++;
    if (!ok || bus.sr !== e.sr || {bus.n, bus.z, bus.c, bus.v} !== 4'b0110) begin
      errors++;
      $display("FAIL byte_sub: got sr=%h nzcv=%b%b%b%b, expected sr=%h nzcv=0110",
               bus.sr, bus.n, bus.z, bus.c, bus.v, e.sr);
    end
  endtask

  task automatic test_logic_ops;
    exp_t e;
    bit ok;
    step(1'b1, 16'h0000, 16'h00F0, 16'h000F, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    sb_pop(e, ok);
    checks++;
    if (!ok || bus.sr !== e.sr || {bus.n, bus.z, bus.c, bus.v} !== 4'b0100) begin
      errors++;
      $display("FAIL and_flags: got sr=%h nzcv=%b%b%b%b, expected sr=%h nzcv=0100",
               bus.sr, bus.n, bus.z, bus.c, bus.v, e.sr);
    end
    step(1'b1, 16'h0001, 16'h8000, 16'h8001, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    sb_pop(e, ok);
    checks++;
    if (!ok || bus.sr !== e.sr || {bus.n, bus.z, bus.c, bus.v} !== 4'b0011) begin
      errors++;
      $display("FAIL xor_flags: got sr=%h nzcv=%b%b%b%b, expected sr=%h nzcv=0011",
               bus.sr, bus.n, bus.z, bus.c, bus.v, e.sr);
    end
    step(1'b1, 16'h0000, 16'hFFFF, 16'h0000, 4'b0101, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    sb_pop(e, ok);
    checks++;
    if (!ok || bus.sr !== e.sr || bus.sr !== 16'h0101) begin
      errors++;
      $display("FAIL bis_hold: got sr=%h, expected sr=0101", bus.sr);
    end
    step(1'b1, 16'h0000, 16'h0000, 16'h0000, 4'b1100, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    sb_pop(e, ok);
    checks++;
    if (!ok || bus.sr !== e.sr || bus.sr !== 16'h0101) begin
      errors++;
      $display("FAIL bic_hold: got sr=%h, expected sr=0101", bus.sr);
    end
  endtask

  task automatic test_priority;
    exp_t e;
    bit ok;
    step(1'b1, 16'h0000, 16'h0000, 16'h0000, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFE08);
    sb_pop(e, ok);
    checks++;
    if (!ok || bus.sr !== e.sr || bus.sr !== 16'h0008) begin
      errors++;
      $display("FAIL sr_we_priority: got sr=%h, expected sr=0008", bus.sr);
    end
  endtask

  task automatic test_idle_hold;
    exp_t e;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0000, 16'h7FFF, 16'h0001, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
      sb_pop(e, ok);
      checks++;
      if (!ok || bus.sr !== e.sr || bus.sr !== 16'h0008 || bus.res_valid_q !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold[%0d]: got sr=%h rvq=%b, expected sr=0008 rvq=0", i, bus.sr, bus.res_valid_q);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    bit ok;
    logic [3:0] fs;
    for (int i = 0; i < 40; i++) begin
      fs = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 16'($urandom), fs,
           1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 7) == 0), 16'($urandom));
      sb_pop(e, ok);
      checks++;
      if (!ok || bus.sr !== e.sr || bus.res_q !== e.res || bus.res_valid_q !== e.rv ||
          bus.c !== e.sr[0] || bus.z !== e.sr[1] || bus.n !== e.sr[2] || bus.v !== e.sr[8]) begin
        errors++;
        $display("FAIL b2b[%0d]: got sr=%h res=%h rvq=%b, expected sr=%h res=%h rvq=%b",
                 i, bus.sr, bus.res_q, bus.res_valid_q, e.sr, e.res, e.rv);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    model_sr = 16'h0000;
    rst_n    = 1'b0;
    test_reset();
    test_add_overflow();
    test_byte_sub();
    test_logic_ops();
    test_priority();
    test_idle_hold();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
